// File: rtl/frame_buffer_manager.sv
// ----------------------------------------------------------------------------
// frame_buffer_manager: triple-buffer scheduler handing DDR writer/reader bases
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_buffer_manager #(
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0004_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk_100Mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_frame_done,
  input  logic             rd_frame_start,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic [1:0]       wr_idx,
  output logic [1:0]       rd_idx,
  output logic             rd_valid,
  output logic             wr_swap,
  output logic             rd_swap,
  output logic [CNT_W-1:0] frames_written,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_repeated
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] buf_addr(input logic [1:0] idx);
    return BASE_ADDR + ({30'd0, idx} * FRAME_STRIDE);
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       wd_sync_q, rs_sync_q;
  logic [1:0]       w_q, r_q, p_q, w_d, r_d, p_d;
  logic             pend_q, rd_valid_q, wr_swap_q, rd_swap_q;
  logic [31:0]      wr_addr_q, rd_addr_q;
  logic [CNT_W-1:0] written_q, dropped_q, repeated_q;
  logic             wd_p, rs_p, do_wr, do_rd, allow_rep;

  // Stages 0/1 resynchronise; stage 2 only remembers the last level for edge detection
  assign wd_p = wd_sync_q[1] & ~wd_sync_q[2];
  assign rs_p = rs_sync_q[1] & ~rs_sync_q[2];

  always_comb begin
    state_d   = state_q;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    allow_rep = 1'b0;
    case (state_q)
      ST_WAIT_FIRST: begin
        do_wr = wd_p;
        do_rd = rs_p;
        if (wd_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        do_rd     = rs_p;
        allow_rep = 1'b1;
        if (wd_p && !en) state_d = ST_IDLE;
        else             do_wr   = wd_p;
      end
      default: begin
        do_rd     = rs_p;
        allow_rep = 1'b1;
        state_d   = (wd_p && en) ? ST_WAIT_FIRST : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_d = w_q;
    r_d = r_q;
    p_d = p_q;
    if (do_wr && do_rd) begin
      w_d = p_q;
      r_d = w_q;
      p_d = r_q;
    end else if (do_wr) begin
      w_d = p_q;
      p_d = w_q;
    end else if (do_rd && pend_q) begin
      r_d = p_q;
      p_d = r_q;
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wd_sync_q  <= 3'b000;
      rs_sync_q  <= 3'b000;
      w_q        <= 2'd0;
      r_q        <= 2'd1;
      p_q        <= 2'd2;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_swap_q  <= 1'b0;
      rd_swap_q  <= 1'b0;
      wr_addr_q  <= buf_addr(2'd0);
      rd_addr_q  <= buf_addr(2'd1);
      written_q  <= '0;
      dropped_q  <= '0;
      repeated_q <= '0;
    end else begin
      state_q   <= state_d;
      wd_sync_q <= {wd_sync_q[1:0], wr_frame_done};
      rs_sync_q <= {rs_sync_q[1:0], rd_frame_start};
      w_q       <= w_d;
      r_q       <= r_d;
      p_q       <= p_d;
      wr_addr_q <= buf_addr(w_d);
      rd_addr_q <= buf_addr(r_d);
      wr_swap_q <= do_wr;
      rd_swap_q <= do_rd && (do_wr || pend_q);
      if (do_wr && do_rd) begin
        pend_q     <= 1'b0;
        rd_valid_q <= 1'b1;
      end else if (do_wr) begin
        pend_q <= 1'b1;
      end else if (do_rd && pend_q) begin
        pend_q     <= 1'b0;
        rd_valid_q <= 1'b1;
      end
      if (do_wr) begin
        written_q <= written_q + C_ONE;
        if (pend_q) dropped_q <= dropped_q + C_ONE;
      end
      if (do_rd && !do_wr && !pend_q && rd_valid_q && allow_rep)
        repeated_q <= repeated_q + C_ONE;
    end
  end

  assign wr_base_addr    = wr_addr_q;
  assign rd_base_addr    = rd_addr_q;
  assign wr_idx          = w_q;
  assign rd_idx          = r_q;
  assign rd_valid        = rd_valid_q;
  assign wr_swap         = wr_swap_q;
  assign rd_swap         = rd_swap_q;
  assign frames_written  = written_q;
  assign frames_dropped  = dropped_q;
  assign frames_repeated = repeated_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_manager.sv
// ----------------------------------------------------------------------------
// tb_frame_buffer_manager: scoreboard bench for the triple-buffer scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_frame_buffer_manager;

  logic        clk_100Mhz = 1'b0;
  logic        rst = 1'b1, en = 1'b0, wr_frame_done = 1'b0, rd_frame_start = 1'b0;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic [1:0]  wr_idx, rd_idx;
  logic        rd_valid, wr_swap, rd_swap;
  logic [15:0] frames_written, frames_dropped, frames_repeated;

  frame_buffer_manager dut (
    .clk_100Mhz      (clk_100Mhz),
    .rst             (rst),
    .en              (en),
    .wr_frame_done   (wr_frame_done),
    .rd_frame_start  (rd_frame_start),
    .wr_base_addr    (wr_base_addr),
    .rd_base_addr    (rd_base_addr),
    .wr_idx          (wr_idx),
    .rd_idx          (rd_idx),
    .rd_valid        (rd_valid),
    .wr_swap         (wr_swap),
    .rd_swap         (rd_swap),
    .frames_written  (frames_written),
    .frames_dropped  (frames_dropped),
    .frames_repeated (frames_repeated)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct {
    int          cyc;
    bit          ws;
    bit          rs;
    logic [31:0] wa;
    logic [31:0] ra;
    bit          rv;
    int          fw;
    int          fd;
    int          fr;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          inv_en = 1'b0;
  logic [31:0] prev_wa, prev_ra;

  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(bit ws, bit rs, logic [31:0] wa, logic [31:0] ra,
                              bit rv, int fw, int fd, int fr);
    exp_t e;
    e.cyc = 0; e.ws = ws; e.rs = rs; e.wa = wa; e.ra = ra;
    e.rv = rv; e.fw = fw; e.fd = fd; e.fr = fr;
    return e;
  endfunction

  // Raise the selected inputs, hold them several cycles, then release
  task automatic pulse(input bit wd, input bit rsx, input bit has_exp, input exp_t e);
    @(negedge clk_100Mhz);
    if (has_exp) begin
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    wr_frame_done  = wd;
    rd_frame_start = rsx;
    repeat (5) @(negedge clk_100Mhz);
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
    repeat (4) @(negedge clk_100Mhz);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_base"}, wr_base_addr, 32'h0100_0000);
    chk({tag, "_rd_base"}, rd_base_addr, 32'h0104_0000);
    chk({tag, "_wr_idx"}, 32'(wr_idx), 32'd0);
    chk({tag, "_rd_idx"}, 32'(rd_idx), 32'd1);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_swaps"}, 32'({wr_swap, rd_swap}), 32'd0);
    chk({tag, "_written"}, 32'(frames_written), 32'd0);
    chk({tag, "_dropped"}, 32'(frames_dropped), 32'd0);
    chk({tag, "_repeated"}, 32'(frames_repeated), 32'd0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each swap
  always @(negedge clk_100Mhz) begin
    if (inv_en && !rst) begin
      chk("r_ne_w", 32'(rd_idx != wr_idx), 32'd1);
      chk("wr_addr_only_on_swap", 32'((wr_base_addr == prev_wa) || wr_swap), 32'd1);
      chk("rd_addr_only_on_swap", 32'((rd_base_addr == prev_ra) || rd_swap), 32'd1);
      if (wr_swap || rd_swap) begin
        if (sb.size() == 0) begin
          chk("unexpected_swap", 32'({wr_swap, rd_swap}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("swap_cycle", cyc, e.cyc);
          chk("wr_swap", 32'(wr_swap), 32'(e.ws));
          chk("rd_swap", 32'(rd_swap), 32'(e.rs));
          chk("wr_base_addr", wr_base_addr, e.wa);
          chk("rd_base_addr", rd_base_addr, e.ra);
          chk("rd_valid", 32'(rd_valid), 32'(e.rv));
          chk("frames_written", 32'(frames_written), e.fw);
          chk("frames_dropped", 32'(frames_dropped), e.fd);
          chk("frames_repeated", 32'(frames_repeated), e.fr);
        end
      end
    end
    prev_wa = wr_base_addr;
    prev_ra = rd_base_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_100Mhz);
    check_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk_100Mhz);
    check_reset("rst_release");
    inv_en = 1'b1;

    // First boundary only arms; second completes the first frame (W0<->P2)
    en = 1'b1;
    pulse(1, 0, 0, none);
    pulse(1, 0, 1, mk(1, 0, 32'h0108_0000, 32'h0104_0000, 0, 1, 0, 0));
    // Reader takes it: R=0, P=1
    pulse(0, 1, 1, mk(0, 1, 32'h0108_0000, 32'h0100_0000, 1, 1, 0, 0));

    // Three writes, no reads: W 2->1->2->1, two frames dropped
    pulse(1, 0, 1, mk(1, 0, 32'h0104_0000, 32'h0100_0000, 1, 2, 0, 0));
    pulse(1, 0, 1, mk(1, 0, 32'h0108_0000, 32'h0100_0000, 1, 3, 1, 0));
    pulse(1, 0, 1, mk(1, 0, 32'h0104_0000, 32'h0100_0000, 1, 4, 2, 0));
    chk("rd_idx_held", 32'(rd_idx), 32'd0);

    // One write then two reads: second read repeats
    pulse(1, 0, 1, mk(1, 0, 32'h0108_0000, 32'h0100_0000, 1, 5, 3, 0));
    pulse(0, 1, 1, mk(0, 1, 32'h0108_0000, 32'h0104_0000, 1, 5, 3, 0));
    pulse(0, 1, 0, none);
    chk("repeat_count", 32'(frames_repeated), 32'd1);
    chk("repeat_rd_base", rd_base_addr, 32'h0104_0000);

    // Make pend=1, then simultaneous write+read rotation
    pulse(1, 0, 1, mk(1, 0, 32'h0100_0000, 32'h0104_0000, 1, 6, 3, 1));
    pulse(1, 1, 1, mk(1, 1, 32'h0108_0000, 32'h0100_0000, 1, 7, 4, 1));

    // Rotation disabled: write frame discarded, reader state held
    en = 1'b0;
    pulse(1, 0, 0, none);
    chk("idle_rd_valid", 32'(rd_valid), 32'd1);
    chk("idle_written", 32'(frames_written), 32'd7);
    chk("idle_wr_idx", 32'(wr_idx), 32'd2);
    en = 1'b1;
    pulse(1, 0, 0, none);
    pulse(1, 0, 1, mk(1, 0, 32'h0104_0000, 32'h0100_0000, 1, 8, 4, 1));

    // Reset while a boundary is in the synchroniser
    inv_en = 1'b0;
    wr_frame_done = 1'b1;
    repeat (2) @(negedge clk_100Mhz);
    rst = 1'b1;
    wr_frame_done = 1'b0;
    @(negedge clk_100Mhz);
    check_reset("rst_mid");
    rst = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    check_reset("rst_after");
    inv_en = 1'b1;
    pulse(1, 0, 0, none);
    pulse(1, 0, 1, mk(1, 0, 32'h0108_0000, 32'h0104_0000, 0, 1, 0, 0));

    repeat (10) @(negedge clk_100Mhz);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
